ts_cc_monitor: RTL
==================

TS_CC_MONITOR -- requirements
Module: ts_cc_monitor

Interface
REQ-001 SHALL have parameter TARGET_PID, default 13'h0100: PID whose continuity counter is checked.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port byte_in, input, 8: TS byte from the sync-recovery stage.
REQ-005 SHALL have port byte_valid, input, 1: byte_in qualifier.
REQ-006 SHALL have port sync_in, input, 1: high with byte_valid on a recovered 0x47 packet-start byte.
REQ-007 SHALL have port hdr_valid, output, 1: one-cycle pulse, header fields valid.
REQ-008 SHALL have port pid_out, output, 13: PID of the last parsed header.
REQ-009 SHALL have port cc_out, output, 4: continuity counter of the last parsed header.
REQ-010 SHALL have port tei_err, output, 1: one-cycle pulse, transport_error_indicator set.
REQ-011 SHALL have port cc_err, output, 1: one-cycle pulse, TARGET_PID CC discontinuity.
REQ-012 SHALL have port sync_lost, output, 1: one-cycle pulse, no sync_in at expected packet start.
REQ-013 SHALL have port pkt_count, output, 16: headers parsed, wraps at 0xFFFF->0.
REQ-014 SHALL have port cc_err_count, output, 16: cc_err pulses, saturates at 0xFFFF.

Function
REQ-015 SHALL advance all parsing state only on cycles with byte_valid=1; byte_valid=0 cycles hold state.
REQ-016 SHALL implement states HUNT, HDR1, HDR2, HDR3, PAYLOAD.
REQ-017 HUNT: byte_valid & sync_in & byte_in==8'h47 -> HDR1, byte index=1; all other bytes ignored.
REQ-018 HDR1: capture TEI=byte_in[7], PID[12:8]=byte_in[4:0]; -> HDR2.
REQ-019 HDR2: capture PID[7:0]=byte_in; -> HDR3.
REQ-020 HDR3: capture AFC=byte_in[5:4], CC=byte_in[3:0]; -> PAYLOAD, index=4.
REQ-021 PAYLOAD: increment index per valid byte; byte at index 188 (next packet start) with sync_in=1 -> HDR1, index=1.
REQ-022 Expected packet-start byte with sync_in=0 -> HUNT, sync_lost pulse next cycle, cc_init cleared.
REQ-023 hdr_valid, pid_out, cc_out, tei_err, cc_err SHALL update on the clock edge after the HDR3 byte is accepted (1-cycle latency); pkt_count increments same edge.
REQ-024 Packets with TEI=1 SHALL pulse tei_err and SHALL NOT evaluate or update CC state.
REQ-025 For PID==TARGET_PID, TEI=0, cc_init=0: store CC as last_cc, set cc_init, no error.
REQ-026 For PID==TARGET_PID, TEI=0, cc_init=1, AFC in {01,11} (payload): CC==last_cc+1 mod 16 -> ok, dup_seen cleared; CC==last_cc and dup_seen=0 -> ok (single duplicate), dup_seen set; otherwise cc_err.
REQ-027 For AFC in {00,10} (no payload): CC==last_cc -> ok; otherwise cc_err.
REQ-028 On cc_err, last_cc SHALL load received CC, dup_seen cleared; cc_err_count increments unless 0xFFFF.
REQ-029 Headers with PID!=TARGET_PID SHALL pulse hdr_valid and count in pkt_count only.
REQ-030 Pulse outputs SHALL be low on every cycle not explicitly specified.
REQ-031 4-bit CC wrap 15->0 SHALL be a valid increment.

Reset
REQ-032 rst=1 SHALL asynchronously force state=HUNT, index=0, cc_init=0, dup_seen=0, last_cc=0, all outputs 0.
REQ-033 rst asserted mid-packet SHALL discard the partial header; first packet after release is an init packet (no cc_err).

Verification
REQ-034 Ten back-to-back TARGET_PID packets, AFC=01, CC 0..9 -> 10 hdr_valid pulses, pkt_count=10, cc_err never high.
REQ-035 TARGET_PID CC sequence 14,15,0,2 -> single cc_err on fourth header, cc_err_count=1.
REQ-036 CC sequence 3,3,3 with AFC=01 -> second header ok, third header cc_err.
REQ-037 Packet with byte 1=8'hA1 -> tei_err pulse, pid_out=13'h01xx, CC state unchanged for next packet.
REQ-038 Drop sync_in on byte 188 -> sync_lost pulse, state HUNT; next TARGET_PID packet with any CC -> no cc_err.
REQ-039 Random byte_valid gaps (50% duty) on REQ-034 stream -> identical outputs to gapless run, only delayed.

Source files
------------

// File: rtl/ts_cc_monitor.sv
// rtl/ts_cc_monitor.sv - TS header parser with continuity-counter checking for one PID
module ts_cc_monitor #(
    parameter logic [12:0] TARGET_PID = 13'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        sync_in,
    output logic        hdr_valid,
    output logic [12:0] pid_out,
    output logic [3:0]  cc_out,
    output logic        tei_err,
    output logic        cc_err,
    output logic        sync_lost,
    output logic [15:0] pkt_count,
    output logic [15:0] cc_err_count
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_PAYLOAD
    } state_t;

    localparam logic [7:0] PKT_LEN = 8'd188;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_idx;
    logic [7:0]  w_next_idx;
    logic        w_start_bad;

    logic        r_tei;
    logic [4:0]  r_pid_hi;
    logic [7:0]  r_pid_lo;
    logic        r_cc_init;
    logic        r_dup_seen;
    logic [3:0]  r_last_cc;

    logic        r_hdr_valid;
    logic [12:0] r_pid_out;
    logic [3:0]  r_cc_out;
    logic        r_tei_err;
    logic        r_cc_err;
    logic        r_sync_lost;
    logic [15:0] r_pkt_count;
    logic [15:0] r_cc_err_count;

    logic        w_hdr_done;
    logic [12:0] w_pid;
    logic [3:0]  w_cc;
    logic        w_payload;
    logic [3:0]  w_last_inc;
    logic        w_is_target;
    logic        w_cc_ok;
    logic        w_cc_bad;

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_start_bad  = 1'b0;
        if (byte_valid) begin
            case (r_state)
                S_HUNT: begin
                    if (sync_in && byte_in == 8'h47) begin
                        w_next_state = S_HDR1;
                        w_next_idx   = 8'd1;
                    end
                end
                S_HDR1: begin
                    w_next_state = S_HDR2;
                    w_next_idx   = 8'd2;
                end
                S_HDR2: begin
                    w_next_state = S_HDR3;
                    w_next_idx   = 8'd3;
                end
                S_HDR3: begin
                    w_next_state = S_PAYLOAD;
                    w_next_idx   = 8'd4;
                end
                S_PAYLOAD: begin
                    // Index 188 is the first byte of the following packet
                    if (r_idx == PKT_LEN) begin
                        if (sync_in) begin
                            w_next_state = S_HDR1;
                            w_next_idx   = 8'd1;
                        end else begin
                            w_next_state = S_HUNT;
                            w_next_idx   = 8'd0;
                            w_start_bad  = 1'b1;
                        end
                    end else begin
                        w_next_idx = r_idx + 8'd1;
                    end
                end
                default: begin
                    w_next_state = S_HUNT;
                    w_next_idx   = 8'd0;
                end
            endcase
        end
    end

    assign w_hdr_done  = byte_valid && (r_state == S_HDR3);
    assign w_pid       = {r_pid_hi, r_pid_lo};
    assign w_cc        = byte_in[3:0];
    assign w_payload   = byte_in[4];
    assign w_last_inc  = r_last_cc + 4'd1;
    assign w_is_target = !r_tei && (w_pid == TARGET_PID);

    // Payload-bearing packets may repeat CC once; header-only packets must repeat it
    always_comb begin
        w_cc_ok = 1'b0;
        if (w_payload) begin
            w_cc_ok = (w_cc == w_last_inc) || (w_cc == r_last_cc && !r_dup_seen);
        end else begin
            w_cc_ok = (w_cc == r_last_cc);
        end
    end

    assign w_cc_bad = w_hdr_done && w_is_target && r_cc_init && !w_cc_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_HUNT;
            r_idx          <= 8'd0;
            r_tei          <= 1'b0;
            r_pid_hi       <= 5'd0;
            r_pid_lo       <= 8'd0;
            r_cc_init      <= 1'b0;
            r_dup_seen     <= 1'b0;
            r_last_cc      <= 4'd0;
            r_hdr_valid    <= 1'b0;
            r_pid_out      <= 13'd0;
            r_cc_out       <= 4'd0;
            r_tei_err      <= 1'b0;
            r_cc_err       <= 1'b0;
            r_sync_lost    <= 1'b0;
            r_pkt_count    <= 16'd0;
            r_cc_err_count <= 16'd0;
        end else begin
            r_state     <= w_next_state;
            r_idx       <= w_next_idx;
            r_hdr_valid <= 1'b0;
            r_tei_err   <= 1'b0;
            r_cc_err    <= 1'b0;
            r_sync_lost <= w_start_bad;

            if (byte_valid && r_state == S_HDR1) begin
                r_tei    <= byte_in[7];
                r_pid_hi <= byte_in[4:0];
            end
            if (byte_valid && r_state == S_HDR2) begin
                r_pid_lo <= byte_in;
            end

            if (w_start_bad) begin
                r_cc_init <= 1'b0;
            end

            if (w_hdr_done) begin
                r_hdr_valid <= 1'b1;
                r_pid_out   <= w_pid;
                r_cc_out    <= w_cc;
                r_tei_err   <= r_tei;
                r_cc_err    <= w_cc_bad;
                r_pkt_count <= r_pkt_count + 16'd1;
                if (w_is_target) begin
                    if (!r_cc_init) begin
                        r_last_cc  <= w_cc;
                        r_cc_init  <= 1'b1;
                        r_dup_seen <= 1'b0;
                    end else if (w_cc_bad) begin
                        r_last_cc  <= w_cc;
                        r_dup_seen <= 1'b0;
                        if (r_cc_err_count != 16'hFFFF) begin
                            r_cc_err_count <= r_cc_err_count + 16'd1;
                        end
                    end else if (w_payload) begin
                        if (w_cc == w_last_inc) begin
                            r_last_cc  <= w_cc;
                            r_dup_seen <= 1'b0;
                        end else begin
                            r_dup_seen <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign hdr_valid    = r_hdr_valid;
    assign pid_out      = r_pid_out;
    assign cc_out       = r_cc_out;
    assign tei_err      = r_tei_err;
    assign cc_err       = r_cc_err;
    assign sync_lost    = r_sync_lost;
    assign pkt_count    = r_pkt_count;
    assign cc_err_count = r_cc_err_count;

endmodule
